// File: rtl/dram_arb_pkg.sv
// Shared defaults and types for the two-requester DRAM port arbiter.
package dram_arb_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCK0    = 2'd1,
    LOCK1    = 2'd2
  } arb_state_t;

  typedef logic master_id_t;

endpackage

// File: rtl/arb_pick2.sv
// Combinational 2-way picker: the lock owner is exclusive, otherwise `prefer` breaks ties.
module arb_pick2
  import dram_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  master_id_t i_prefer,
  input  logic       i_locked,
  input  master_id_t i_owner,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    if (i_locked) begin
      o_gnt[i_owner] = i_req[i_owner];
    end else if (i_req == 2'b11) begin
      o_gnt[i_prefer] = 1'b1;
    end else begin
      o_gnt = i_req;
    end
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Single-port DRAM arbiter for m0 (LSU) and m1 (DMA) with bounded lock ownership.
// Define DRAM_ARB_RR_EN for round-robin arbitration; default is fixed priority m0 > m1.
//   state    | meaning
//   UNLOCKED | open arbitration between m0 and m1
//   LOCK0    | m0 owns the port until it drops lock or hits MAX_LOCK beats
//   LOCK1    | m1 owns the port until it drops lock or hits MAX_LOCK beats
module dram_port_arbiter
  import dram_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_LOCK = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_m0_req,
  input  logic              i_m0_we,
  input  logic              i_m0_lock,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  output logic              o_m0_gnt,
  output logic              o_m0_rvalid,
  output logic [DATA_W-1:0] o_m0_rdata,
  input  logic              i_m1_req,
  input  logic              i_m1_we,
  input  logic              i_m1_lock,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic              o_m1_gnt,
  output logic              o_m1_rvalid,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic [DATA_W-1:0] o_ram_data,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_we,
  input  logic [DATA_W-1:0] i_ram_q
);

  localparam int               CNT_W   = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

  arb_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_lock_cnt, w_lock_cnt_nxt, w_cnt_inc;
  logic             r_starve_fix, w_starve_fix_nxt;
  master_id_t       r_fix_pref, w_fix_pref_nxt;
  logic [1:0]       r_rvalid;
  logic [1:0]       w_req, w_we, w_lock, w_gnt;
  logic             w_locked;
  master_id_t       w_owner, w_gnt_id, w_prefer, w_rr_pref;

  assign w_req    = {i_m1_req, i_m0_req};
  assign w_we     = {i_m1_we, i_m0_we};
  assign w_lock   = {i_m1_lock, i_m0_lock};
  assign w_locked = (r_state != UNLOCKED);
  assign w_owner  = (r_state == LOCK1);
  assign w_gnt_id = w_gnt[1];

`ifdef DRAM_ARB_RR_EN
  master_id_t r_last_gnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_gnt <= 1'b1;
    end else if (|w_gnt) begin
      r_last_gnt <= w_gnt_id;
    end
  end

  assign w_rr_pref = ~r_last_gnt;
`else
  assign w_rr_pref = 1'b0;
`endif

  assign w_prefer = r_starve_fix ? r_fix_pref : w_rr_pref;

  arb_pick2 u_pick (
    .i_req    (w_req),
    .i_prefer (w_prefer),
    .i_locked (w_locked),
    .i_owner  (w_owner),
    .o_gnt    (w_gnt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= UNLOCKED;
      r_lock_cnt   <= '0;
      r_starve_fix <= 1'b0;
      r_fix_pref   <= 1'b0;
      r_rvalid     <= 2'b00;
    end else begin
      r_state      <= w_state_nxt;
      r_lock_cnt   <= w_lock_cnt_nxt;
      r_starve_fix <= w_starve_fix_nxt;
      r_fix_pref   <= w_fix_pref_nxt;
      r_rvalid     <= w_gnt & ~w_we;
    end
  end

  // A lock beat that reaches MAX_LOCK hands the next contested grant to the other side.
  assign w_cnt_inc = (w_locked ? r_lock_cnt : '0) + CNT_W'(1);

  always_comb begin
    w_state_nxt      = r_state;
    w_lock_cnt_nxt   = r_lock_cnt;
    w_starve_fix_nxt = r_starve_fix;
    w_fix_pref_nxt   = r_fix_pref;
    if (!w_locked) begin
      if (|w_gnt) begin
        w_starve_fix_nxt = 1'b0;
        if (w_lock[w_gnt_id]) begin
          if (w_cnt_inc == CNT_MAX) begin
            w_starve_fix_nxt = 1'b1;
            w_fix_pref_nxt   = ~w_gnt_id;
            w_lock_cnt_nxt   = '0;
          end else begin
            w_state_nxt    = w_gnt_id ? LOCK1 : LOCK0;
            w_lock_cnt_nxt = w_cnt_inc;
          end
        end
      end
    end else if ((|w_gnt) && (w_cnt_inc == CNT_MAX)) begin
      w_state_nxt      = UNLOCKED;
      w_lock_cnt_nxt   = '0;
      w_starve_fix_nxt = 1'b1;
      w_fix_pref_nxt   = ~w_owner;
    end else if (!w_lock[w_owner]) begin
      w_state_nxt    = UNLOCKED;
      w_lock_cnt_nxt = '0;
    end else if (|w_gnt) begin
      w_lock_cnt_nxt = w_cnt_inc;
    end
  end

  always_comb begin
    o_ram_we   = 1'b0;
    o_ram_addr = '0;
    o_ram_data = '0;
    if (w_gnt[0]) begin
      o_ram_we   = i_m0_we;
      o_ram_addr = i_m0_addr;
      o_ram_data = i_m0_wdata;
    end else if (w_gnt[1]) begin
      o_ram_we   = i_m1_we;
      o_ram_addr = i_m1_addr;
      o_ram_data = i_m1_wdata;
    end
  end

  assign o_m0_gnt    = w_gnt[0];
  assign o_m1_gnt    = w_gnt[1];
  assign o_m0_rvalid = r_rvalid[0];
  assign o_m1_rvalid = r_rvalid[1];
  assign o_m0_rdata  = i_ram_q;
  assign o_m1_rdata  = i_ram_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: directed scenarios plus random traffic vs a reference model.
module tb_dram_port_arbiter;
  import dram_arb_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int ML = 4;
`ifdef DRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req [2];
  logic we [2];
  logic lock [2];
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];
  logic o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid, o_ram_we;
  logic [DW-1:0] o_m0_rdata, o_m1_rdata, o_ram_data, ram_q;
  logic [AW-1:0] o_ram_addr;
  logic [DW-1:0] mem [4096];

  always #5 clk = ~clk;

  dram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m0_req(req[0]), .i_m0_we(we[0]), .i_m0_lock(lock[0]), .i_m0_addr(addr[0]),
    .i_m0_wdata(wdata[0]), .o_m0_gnt(o_m0_gnt), .o_m0_rvalid(o_m0_rvalid), .o_m0_rdata(o_m0_rdata),
    .i_m1_req(req[1]), .i_m1_we(we[1]), .i_m1_lock(lock[1]), .i_m1_addr(addr[1]),
    .i_m1_wdata(wdata[1]), .o_m1_gnt(o_m1_gnt), .o_m1_rvalid(o_m1_rvalid), .o_m1_rdata(o_m1_rdata),
    .o_ram_data(o_ram_data), .o_ram_addr(o_ram_addr), .o_ram_we(o_ram_we), .i_ram_q(ram_q)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return (i == 5) ? 32'hDEADBEEF : ((32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000);
  endfunction

  // RAM with registered address: q reflects memory as it was before this edge's write.
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = init_word(i);
    ram_q = '0;
    forever begin
      @(posedge clk);
      if (o_ram_we) mem[o_ram_addr] <= o_ram_data;
      ram_q <= mem[o_ram_addr];
    end
  end

  int n_total = 0;
  int n_bad = 0;
  int m_owner, m_cnt, m_fix_pref, m_last, g_w;
  bit m_fix;
  bit m_rv [2];
  logic [DW-1:0] m_rd;
  logic [DW-1:0] sh [4096];
  logic g_we;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_last = 1; m_fix = 0; m_fix_pref = 0;
    m_rv[0] = 0; m_rv[1] = 0; m_rd = '0;
  endtask

  // Who should get the port this cycle, from the arbitration rules.
  function automatic int model_winner();
    if (m_owner >= 0) return req[m_owner] ? m_owner : -1;
    if (req[0] && req[1]) begin
      if (m_fix) return m_fix_pref;
      return RR ? 1 - m_last : 0;
    end
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  task automatic model_step(input int w);
    m_rv[0] = 0; m_rv[1] = 0;
    if (w >= 0) begin
      m_last = w;
      if (we[w]) sh[addr[w]] = wdata[w];
      else begin m_rv[w] = 1; m_rd = sh[addr[w]]; end
    end
    if (m_owner < 0) begin
      if (w >= 0) begin
        m_fix = 0;
        if (lock[w]) begin
          if (ML == 1) begin m_fix = 1; m_fix_pref = 1 - w; end
          else begin m_owner = w; m_cnt = 1; end
        end
      end
    end else begin
      if (w >= 0) m_cnt++;
      if (m_cnt == ML) begin
        m_fix = 1; m_fix_pref = 1 - m_owner; m_owner = -1; m_cnt = 0;
      end else if (!lock[m_owner]) begin
        m_owner = -1; m_cnt = 0;
      end
    end
  endtask

  task automatic tick();
    logic exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    @(negedge clk);
    g_w = model_winner();
    exp_we = 1'b0; exp_addr = '0; exp_data = '0;
    if (g_w >= 0) begin exp_we = we[g_w]; exp_addr = addr[g_w]; exp_data = wdata[g_w]; end
    g_we = o_ram_we;
    chk("m0_gnt", 32'(o_m0_gnt), 32'(g_w == 0));
    chk("m1_gnt", 32'(o_m1_gnt), 32'(g_w == 1));
    chk("ram_we", 32'(o_ram_we), 32'(exp_we));
    chk("ram_addr", 32'(o_ram_addr), 32'(exp_addr));
    chk("ram_data", o_ram_data, exp_data);
    chk("m0_rvalid", 32'(o_m0_rvalid), 32'(m_rv[0]));
    chk("m1_rvalid", 32'(o_m1_rvalid), 32'(m_rv[1]));
    if (m_rv[0]) chk("m0_rdata", o_m0_rdata, m_rd);
    if (m_rv[1]) chk("m1_rdata", o_m1_rdata, m_rd);
    @(posedge clk);
    model_step(g_w);
    #1;
  endtask

  task automatic drv(input int m, input logic r, input logic w, input logic l,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[m] = r; we[m] = w; lock[m] = l; addr[m] = a; wdata[m] = d;
  endtask

  task automatic idle_all();
    drv(0, 0, 0, 0, '0, '0);
    drv(1, 0, 0, 0, '0, '0);
  endtask

  initial begin
    int beats0, nrec;
    int rec [5];
    for (int i = 0; i < 4096; i++) sh[i] = init_word(i);
    idle_all();
    model_reset();
    g_w = -1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m0_gnt", 32'(o_m0_gnt), 0);
    chk("rst_m1_gnt", 32'(o_m1_gnt), 0);
    chk("rst_ram_we", 32'(o_ram_we), 0);
    chk("rst_ram_addr", 32'(o_ram_addr), 0);
    chk("rst_ram_data", o_ram_data, 0);
    chk("rst_m0_rvalid", 32'(o_m0_rvalid), 0);
    chk("rst_m1_rvalid", 32'(o_m1_rvalid), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // single read of preloaded word
    drv(0, 1, 0, 0, 12'd5, '0);
    tick();
    chk("t1_grant", 32'(g_w), 0);
    drv(0, 0, 0, 0, '0, '0);
    chk("t1_rvalid", 32'(o_m0_rvalid), 1);
    chk("t1_rdata", o_m0_rdata, 32'hDEADBEEF);
    chk("t1_m1_rvalid", 32'(o_m1_rvalid), 0);
    tick();

    // write then read back
    drv(1, 1, 1, 0, 12'h123, 32'hA5A5A5A5);
    tick();
    chk("t2_we", 32'(g_we), 1);
    drv(1, 1, 0, 0, 12'h123, '0);
    tick();
    chk("t2_rd_we", 32'(g_we), 0);
    drv(1, 0, 0, 0, '0, '0);
    chk("t2_rvalid", 32'(o_m1_rvalid), 1);
    chk("t2_rdata", o_m1_rdata, 32'hA5A5A5A5);
    tick();

    // contention, both read continuously
    drv(0, 1, 0, 0, 12'd40, '0);
    drv(1, 1, 0, 0, 12'd41, '0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t3_grant", 32'(g_w), RR ? 32'(i % 2) : 32'd0);
    end
    idle_all();
    tick(); tick();

    // m1 locked burst, m0 waits
    for (int i = 0; i < 4; i++) begin
      drv(1, 1, 1, (i < 3), 12'(1024 + i), 32'h1000 + 32'(i));
      tick();
      chk("t4_m1_beat", 32'(g_w), 1);
      if (i == 0) drv(0, 1, 0, 0, 12'd1025, '0);
    end
    drv(1, 0, 0, 0, '0, '0);
    tick();
    chk("t4_m0_after", 32'(g_w), 0);
    idle_all();
    tick(); tick();

    // forced release after ML beats
    beats0 = 0; nrec = 0;
    for (int c = 0; c < 40 && beats0 < 10; c++) begin
      drv(0, 1, 0, 1, 12'(20 + beats0), '0);
      tick();
      if (g_w == 0) beats0++;
      if (g_w >= 0 && nrec < 5) begin rec[nrec] = g_w; nrec++; end
      if (c == 0) drv(1, 1, 0, 0, 12'd30, '0);
    end
    chk("t5_m0_beats", 32'(beats0), 10);
    chk("t5_nrec", 32'(nrec), 5);
    for (int i = 0; i < 5; i++) chk("t5_seq", 32'(rec[i]), (i < 4) ? 32'd0 : 32'd1);
    idle_all();
    tick(); tick(); tick();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!req[m] || g_w == m) begin
          if ($urandom_range(0, 9) < 6)
            drv(m, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 4),
                12'($urandom_range(0, 15)), $urandom);
          else begin
            req[m] = 1'b0;
            lock[m] = 1'($urandom_range(0, 1));
          end
        end
      end
      tick();
    end
    idle_all();
    tick(); tick(); tick();

    // async reset during pending read under lock
    drv(0, 1, 0, 1, 12'd5, '0);
    tick();
    chk("t6_grant", 32'(g_w), 0);
    chk("t6_pre_rvalid", 32'(o_m0_rvalid), 1);
    idle_all();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_rvalid_drop", 32'(o_m0_rvalid), 0);
    chk("t6_state", 32'(dut.r_state), 32'(UNLOCKED));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    drv(0, 1, 0, 0, 12'd6, '0);
    drv(1, 1, 0, 0, 12'd7, '0);
    tick();
    chk("t6_first_tie", 32'(g_w), 0);
    idle_all();
    tick(); tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
